serial_in_ext: RTL and testbench
================================

SERIAL_IN_EXT -- requirements
Module: serial_in_ext

Interface
REQ-001 SHALL have parameter CLK_HZ, default 56842105, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, line rate; bit period DIV = CLK_HZ/BAUD_RATE (integer division, truncating), DIV >= 8.
REQ-003 SHALL have parameter DATA_BITS, default 8, legal 5..8, LSB first on the line.
REQ-004 SHALL have parameter PARITY, default 0, meaning 0 none, 1 even, 2 odd.
REQ-005 SHALL have parameter STOP_BITS, default 1, legal 1 or 2.
REQ-006 SHALL have port i_clock, input, 1, the only clock; all logic on its rising edge.
REQ-007 SHALL have port i_reset, input, 1, synchronous, active-high.
REQ-008 SHALL have port i_serial_rx, input, 1, asynchronous serial line, idle high.
REQ-009 SHALL have port o_data, output, DATA_BITS, received word.
REQ-010 SHALL have port o_valid, output, 1, o_data and per-word flags valid.
REQ-011 SHALL have port i_ready, input, 1, consumer accepts the word.
REQ-012 SHALL have port o_frame_err, output, 1, stop bit sampled low; qualified by o_valid.
REQ-013 SHALL have port o_parity_err, output, 1, parity mismatch; qualified by o_valid; always 0 when PARITY=0.
REQ-014 SHALL have port o_overrun, output, 1, one-cycle pulse when a completed word is dropped.
REQ-015 SHALL have port o_break, output, 1, break condition present.
REQ-016 SHALL have port o_busy, output, 1, high in every state except IDLE.

Function
REQ-017 SHALL pass i_serial_rx through a 2-flop synchroniser (reset value 1); all decisions use the synchronised signal rxs.
REQ-018 SHALL implement states IDLE, START, DATA, PAR, STOP, WAIT_HIGH.
REQ-019 IDLE: rxs=0 while armed -> START, bit counter cleared; the armed flag sets on the first cycle rxs=1 after reset.
REQ-020 Each sample value SHALL be the majority of rxs over the 3 cycles ending at the sample point.
REQ-021 START: sample point at DIV/2 cycles after entry; sample 1 -> IDLE (glitch, no output); sample 0 -> DATA.
REQ-022 DATA/PAR/STOP: sample points every DIV cycles after the previous one; DATA takes DATA_BITS samples, then PAR if PARITY!=0, else STOP.
REQ-023 PAR: parity error when XOR(data bits, parity bit) is 1 for even or 0 for odd.
REQ-024 STOP: STOP_BITS samples; all high -> deliver word, go IDLE; any low -> go WAIT_HIGH immediately after that sample.
REQ-025 Frame with stop low and data, parity and stop all 0 SHALL be a break: word not delivered, o_break=1 from the cycle after the failing sample until rxs=1 in WAIT_HIGH.
REQ-026 Other stop-low frames SHALL be delivered with o_frame_err=1.
REQ-027 WAIT_HIGH -> IDLE on first cycle rxs=1.
REQ-028 Delivery: o_valid, o_data and flags update on the cycle after the final stop sample; latency = 1 clock.
REQ-029 o_valid SHALL hold with o_data and flags stable until a cycle with o_valid&i_ready, then deassert next cycle unless a new word loads.
REQ-030 New word completing while o_valid=1 and i_ready=0: word dropped, held word kept, o_overrun high for exactly 1 cycle.
REQ-031 New word completing in the same cycle as o_valid&i_ready: old word accepted, new word loaded, o_valid stays 1, no overrun.
REQ-032 Bit counter width SHALL be ceil(log2(DIV))+1; no wrap within a frame.

Reset
REQ-033 During i_reset: state IDLE, armed 0, synchroniser 1, o_valid 0, o_data 0, o_frame_err 0, o_parity_err 0, o_overrun 0, o_break 0, o_busy 0.
REQ-034 Reset mid-frame SHALL discard the partial word; line held low at reset release SHALL NOT start a frame until rxs has been 1.

Verification (CLK_HZ=1600000, BAUD_RATE=100000, DIV=16)
REQ-035 8N1 frame 0xA5, i_ready=1 -> o_valid one cycle, o_data=0xA5, all flags 0, o_valid 1 clock after stop sample.
REQ-036 PARITY=1, 0x07 sent with parity bit 0 -> o_data=0x07, o_parity_err=1; with parity bit 1 -> o_parity_err=0.
REQ-037 Low pulse of 4 clocks on idle line -> return to IDLE, no o_valid, o_busy high at most DIV/2+3 clocks.
REQ-038 i_ready=0, two frames 0x11 then 0x22 -> o_data stays 0x11, o_overrun one-cycle pulse at second completion.
REQ-039 Line low 20 bit periods then high -> no o_valid, o_break high until rxs returns 1, then next frame 0x3C received correctly.
REQ-040 i_reset asserted mid-DATA with line held low through release -> no output until line high then a valid frame.

Source files
------------

// File: rtl/serial_in_ext.sv
// UART-style serial receiver with majority-vote sampling, optional parity, break detection
// and a single-entry valid/ready output holding register with overrun reporting.
module serial_in_ext #(
   parameter int CLK_HZ    = 56842105,
   parameter int BAUD_RATE = 115200,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic                 i_clock,
   input  logic                 i_reset,
   input  logic                 i_serial_rx,
   output logic [DATA_BITS-1:0] o_data,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic                 o_frame_err,
   output logic                 o_parity_err,
   output logic                 o_overrun,
   output logic                 o_break,
   output logic                 o_busy
);

   localparam int DIV = CLK_HZ / BAUD_RATE;
   localparam int CW  = $clog2(DIV) + 1;
   localparam logic [CW-1:0] HALF = CW'(DIV / 2);
   localparam logic [CW-1:0] FULL = CW'(DIV);
   localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
   localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, WAIT_HIGH} state_t;

   state_t                 state_q, state_d;
   logic                   sync1_q, sync1_d, rxs_q, rxs_d;
   logic [1:0]             hist_q, hist_d;
   logic [1:0]             flush_q, flush_d;
   logic                   armed_q, armed_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [3:0]             bit_q, bit_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic                   any_one_q, any_one_d;
   logic                   par_acc_q, par_acc_d;
   logic                   par_err_q, par_err_d;
   logic [DATA_BITS-1:0]   data_q, data_d;
   logic                   valid_q, valid_d;
   logic                   frame_err_q, frame_err_d;
   logic                   parity_err_q, parity_err_d;
   logic                   overrun_q, overrun_d;
   logic                   break_q, break_d;
   logic                   maj, sample, deliver, deliver_fe;

   assign maj = (rxs_q & hist_q[0]) | (rxs_q & hist_q[1]) | (hist_q[0] & hist_q[1]);

   always_comb begin
      sync1_d      = i_serial_rx;
      rxs_d        = sync1_q;
      hist_d       = {hist_q[0], rxs_q};
      // The synchroniser resets to 1; only trust rxs once both stages carry real line data.
      flush_d      = (flush_q == 2'd2) ? flush_q : flush_q + 2'd1;
      armed_d      = armed_q | ((flush_q == 2'd2) & rxs_q);
      state_d      = state_q;
      cnt_d        = cnt_q;
      bit_d        = bit_q;
      shift_d      = shift_q;
      any_one_d    = any_one_q;
      par_acc_d    = par_acc_q;
      par_err_d    = par_err_q;
      data_d       = data_q;
      valid_d      = valid_q & ~i_ready;
      frame_err_d  = frame_err_q;
      parity_err_d = parity_err_q;
      overrun_d    = 1'b0;
      break_d      = break_q;
      deliver      = 1'b0;
      deliver_fe   = 1'b0;
      sample       = (state_q == START) ? (cnt_q == HALF) : (cnt_q == FULL);

      case (state_q)
         IDLE: begin
            cnt_d     = '0;
            bit_d     = '0;
            any_one_d = 1'b0;
            par_acc_d = 1'b0;
            par_err_d = 1'b0;
            if (armed_q && !rxs_q) state_d = START;
         end
         START: begin
            cnt_d = cnt_q + CW'(1);
            if (sample) begin
               cnt_d   = CW'(1);
               state_d = maj ? IDLE : DATA;
            end
         end
         DATA: begin
            cnt_d = cnt_q + CW'(1);
            if (sample) begin
               cnt_d     = CW'(1);
               shift_d   = {maj, shift_q[DATA_BITS-1:1]};
               any_one_d = any_one_q | maj;
               par_acc_d = par_acc_q ^ maj;
               bit_d     = bit_q + 4'd1;
               if (bit_q == LAST_DATA) begin
                  bit_d   = '0;
                  state_d = (PARITY != 0) ? PAR : STOP;
               end
            end
         end
         PAR: begin
            cnt_d = cnt_q + CW'(1);
            if (sample) begin
               cnt_d     = CW'(1);
               any_one_d = any_one_q | maj;
               par_err_d = (PARITY == 1) ? (par_acc_q ^ maj) : ~(par_acc_q ^ maj);
               state_d   = STOP;
            end
         end
         STOP: begin
            cnt_d = cnt_q + CW'(1);
            if (sample) begin
               cnt_d = CW'(1);
               if (!maj) begin
                  state_d = WAIT_HIGH;
                  if (!any_one_q) begin
                     break_d = 1'b1;
                  end else begin
                     deliver    = 1'b1;
                     deliver_fe = 1'b1;
                  end
               end else begin
                  any_one_d = 1'b1;
                  bit_d     = bit_q + 4'd1;
                  if (bit_q == LAST_STOP) begin
                     deliver = 1'b1;
                     state_d = IDLE;
                  end
               end
            end
         end
         WAIT_HIGH: begin
            if (rxs_q) begin
               state_d = IDLE;
               break_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase

      // A completing word loads only if the holding register is free or being drained now.
      if (deliver) begin
         if (!valid_q || i_ready) begin
            valid_d      = 1'b1;
            data_d       = shift_q;
            frame_err_d  = deliver_fe;
            parity_err_d = par_err_q;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q      <= IDLE;
         sync1_q      <= 1'b1;
         rxs_q        <= 1'b1;
         hist_q       <= 2'b11;
         flush_q      <= 2'd0;
         armed_q      <= 1'b0;
         cnt_q        <= '0;
         bit_q        <= '0;
         shift_q      <= '0;
         any_one_q    <= 1'b0;
         par_acc_q    <= 1'b0;
         par_err_q    <= 1'b0;
         data_q       <= '0;
         valid_q      <= 1'b0;
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
         overrun_q    <= 1'b0;
         break_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         sync1_q      <= sync1_d;
         rxs_q        <= rxs_d;
         hist_q       <= hist_d;
         flush_q      <= flush_d;
         armed_q      <= armed_d;
         cnt_q        <= cnt_d;
         bit_q        <= bit_d;
         shift_q      <= shift_d;
         any_one_q    <= any_one_d;
         par_acc_q    <= par_acc_d;
         par_err_q    <= par_err_d;
         data_q       <= data_d;
         valid_q      <= valid_d;
         frame_err_q  <= frame_err_d;
         parity_err_q <= parity_err_d;
         overrun_q    <= overrun_d;
         break_q      <= break_d;
      end
   end

   assign o_data       = data_q;
   assign o_valid      = valid_q;
   assign o_frame_err  = frame_err_q;
   assign o_parity_err = parity_err_q;
   assign o_overrun    = overrun_q;
   assign o_break      = break_q;
   assign o_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_serial_in_ext.sv
// Directed bench for serial_in_ext: 8N1 instance plus an even-parity instance, DIV = 16.
module tb_serial_in_ext;

   logic       clk = 1'b0;
   logic       srst = 1'b1;
   logic       rx = 1'b1, rx_p = 1'b1;
   logic       ready = 1'b1, ready_p = 1'b1;
   logic [7:0] data, data_p;
   logic       valid, fe, pe, ovr, brk, busy;
   logic       valid_p, fe_p, pe_p, ovr_p, brk_p, busy_p;

   int n_cmp = 0, n_mis = 0;
   int cyc = 0, last_start = 0;
   int rises = 0, vcycles = 0, ovr_cnt = 0, ovr_cyc = 0, busy_cyc = 0, rise_cyc = 0;
   int rises_p = 0, rise_cyc_p = 0;
   logic [7:0] cap_data = '0, cap_data_p = '0;
   logic cap_fe = 1'b0, cap_pe = 1'b0, cap_pe_p = 1'b0;
   logic v_prev = 1'b0, v_prev_p = 1'b0;

   serial_in_ext #(.CLK_HZ(1600000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut (
      .i_clock(clk), .i_reset(srst), .i_serial_rx(rx), .o_data(data), .o_valid(valid),
      .i_ready(ready), .o_frame_err(fe), .o_parity_err(pe), .o_overrun(ovr),
      .o_break(brk), .o_busy(busy));

   serial_in_ext #(.CLK_HZ(1600000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut_p (
      .i_clock(clk), .i_reset(srst), .i_serial_rx(rx_p), .o_data(data_p), .o_valid(valid_p),
      .i_ready(ready_p), .o_frame_err(fe_p), .o_parity_err(pe_p), .o_overrun(ovr_p),
      .o_break(brk_p), .o_busy(busy_p));

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (valid && !v_prev) begin
         rises++; rise_cyc = cyc; cap_data = data; cap_fe = fe; cap_pe = pe;
      end
      if (valid) vcycles++;
      if (ovr) begin ovr_cnt++; ovr_cyc = cyc; end
      if (busy) busy_cyc++;
      v_prev = valid;
      if (valid_p && !v_prev_p) begin
         rises_p++; rise_cyc_p = cyc; cap_data_p = data_p; cap_pe_p = pe_p;
      end
      v_prev_p = valid_p;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_frame(input bit use_p, input logic [7:0] d, input logic par, input logic stop);
      logic [10:0] bits;
      int n;
      bits = '1;
      bits[0] = 1'b0;
      bits[8:1] = d;
      if (use_p) begin bits[9] = par; bits[10] = stop; n = 11; end
      else begin bits[9] = stop; n = 10; end
      last_start = cyc;
      for (int i = 0; i < n; i++) begin
         if (use_p) rx_p = bits[i]; else rx = bits[i];
         repeat (16) @(negedge clk);
      end
      if (use_p) rx_p = 1'b1; else rx = 1'b1;
      repeat (32) @(negedge clk);
      $display("frame line=%0d data=%02h par=%0b stop=%0b start_cyc=%0d", use_p, d, par, stop, last_start);
   endtask

   initial begin
      int r0, v0, o0, b0, s, rp0;

      // reset state
      repeat (3) @(negedge clk);
      check("rst_valid", valid, 0);
      check("rst_data", data, 0);
      check("rst_fe", fe, 0);
      check("rst_pe", pe, 0);
      check("rst_ovr", ovr, 0);
      check("rst_break", brk, 0);
      check("rst_busy", busy, 0);
      check("rst_valid_p", valid_p, 0);
      srst = 1'b0;
      repeat (20) @(negedge clk);

      // 8N1 0xA5 with ready high
      r0 = rises; v0 = vcycles; o0 = ovr_cnt;
      send_frame(0, 8'hA5, 1'b0, 1'b1);
      check("a5_rises", rises - r0, 1);
      check("a5_valid_cycles", vcycles - v0, 1);
      check("a5_data", cap_data, 8'hA5);
      check("a5_fe", cap_fe, 0);
      check("a5_pe", cap_pe, 0);
      check("a5_latency", rise_cyc - last_start, 156);
      check("a5_no_ovr", ovr_cnt - o0, 0);

      // stop bit low with nonzero data: delivered with frame error
      r0 = rises;
      send_frame(0, 8'h55, 1'b0, 1'b0);
      check("fe_rises", rises - r0, 1);
      check("fe_data", cap_data, 8'h55);
      check("fe_flag", cap_fe, 1);
      check("fe_no_break", brk, 0);

      // even parity: 0x07 has odd weight, so parity bit 0 is an error and 1 is clean
      rp0 = rises_p;
      send_frame(1, 8'h07, 1'b0, 1'b1);
      check("par0_rises", rises_p - rp0, 1);
      check("par0_data", cap_data_p, 8'h07);
      check("par0_err", cap_pe_p, 1);
      check("par0_latency", rise_cyc_p - last_start, 172);
      send_frame(1, 8'h07, 1'b1, 1'b1);
      check("par1_rises", rises_p - rp0, 2);
      check("par1_data", cap_data_p, 8'h07);
      check("par1_err", cap_pe_p, 0);

      // 4-clock glitch on idle line
      r0 = rises; b0 = busy_cyc;
      rx = 1'b0;
      repeat (4) @(negedge clk);
      rx = 1'b1;
      repeat (30) @(negedge clk);
      $display("glitch busy_cycles=%0d", busy_cyc - b0);
      check("glitch_no_valid", rises - r0, 0);
      check("glitch_busy_le_11", (busy_cyc - b0) <= 11, 1);
      check("glitch_busy_seen", (busy_cyc - b0) > 0, 1);
      check("glitch_idle", busy, 0);

      // overrun: consumer stalled across two frames
      ready = 1'b0;
      r0 = rises; o0 = ovr_cnt;
      send_frame(0, 8'h11, 1'b0, 1'b1);
      send_frame(0, 8'h22, 1'b0, 1'b1);
      check("ovr_data_kept", data, 8'h11);
      check("ovr_valid_held", valid, 1);
      check("ovr_rises", rises - r0, 1);
      check("ovr_pulse_width", ovr_cnt - o0, 1);
      check("ovr_pulse_time", ovr_cyc - last_start, 156);
      ready = 1'b1;
      @(negedge clk);
      check("ovr_drain", valid, 0);
      $display("overrun drained");

      // break: line low 20 bit periods
      r0 = rises;
      s = cyc;
      rx = 1'b0;
      repeat (200) @(negedge clk);
      check("brk_high", brk, 1);
      check("brk_busy", busy, 1);
      repeat (120) @(negedge clk);
      rx = 1'b1;
      repeat (2) @(negedge clk);
      check("brk_hold_until_rxs", brk, 1);
      @(negedge clk);
      check("brk_clear", brk, 0);
      check("brk_idle", busy, 0);
      check("brk_no_valid", rises - r0, 0);
      $display("break line_low_cycles=%0d", cyc - s);
      repeat (20) @(negedge clk);
      send_frame(0, 8'h3C, 1'b0, 1'b1);
      check("post_brk_rises", rises - r0, 1);
      check("post_brk_data", cap_data, 8'h3C);
      check("post_brk_fe", cap_fe, 0);

      // reset mid-DATA with line held low through release
      r0 = rises;
      rx = 1'b0;
      repeat (40) @(negedge clk);
      srst = 1'b1;
      repeat (3) @(negedge clk);
      check("midrst_valid", valid, 0);
      check("midrst_busy", busy, 0);
      srst = 1'b0;
      b0 = busy_cyc;
      repeat (60) @(negedge clk);
      check("midrst_no_start", busy_cyc - b0, 0);
      check("midrst_no_valid", rises - r0, 0);
      rx = 1'b1;
      repeat (40) @(negedge clk);
      send_frame(0, 8'h5A, 1'b0, 1'b1);
      check("midrst_rises", rises - r0, 1);
      check("midrst_data", cap_data, 8'h5A);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
